// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: colorbar, checkerboard, gradient, solid.
// Define VGA_PATTERN_SCROLL_EN to scroll patterns by one pixel per frame.
module vga_pattern_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_VALID  = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_VALID  = 480,
  parameter int V_FRONT  = 10,
  parameter int SYNC_POL = 0,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [1:0]               mode,
  input  logic [R_W+G_W+B_W-1:0]   solid_rgb,
  output logic [R_W+G_W+B_W-1:0]   rgb,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     de,
  output logic [10:0]              pix_x,
  output logic [10:0]              pix_y,
  output logic                     frame_start
);
  localparam int RGB_W = R_W + G_W + B_W;
  localparam logic [11:0] H_MAX = 12'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
  localparam logic [11:0] V_MAX = 12'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
  localparam logic [11:0] HS_END = 12'(H_SYNC);
  localparam logic [11:0] VS_END = 12'(V_SYNC);
  localparam logic [11:0] HA0 = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] HA1 = 12'(H_SYNC + H_BACK + H_VALID);
  localparam logic [11:0] VA0 = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] VA1 = 12'(V_SYNC + V_BACK + V_VALID);
  localparam logic [10:0] BAR_W = 11'(H_VALID / 8);
  localparam logic SP = 1'(SYNC_POL);
  // Bar colours {R,G,B} indexed left to right: white first, black last.
  localparam logic [7:0][2:0] BAR_LUT = {3'b000, 3'b001, 3'b100, 3'b101,
                                         3'b010, 3'b011, 3'b110, 3'b111};

  logic [11:0] h_cnt, v_cnt;
  logic [1:0]  mode_q;
  logic        h_last, v_last, frame_top, de_c;
  logic [10:0] x_c, y_c, px_pat;
  logic [2:0]  bar;
  logic [RGB_W-1:0] pat;

  assign h_last    = (h_cnt == H_MAX);
  assign v_last    = (v_cnt == V_MAX);
  assign frame_top = (h_cnt == 12'd0) && (v_cnt == 12'd0);
  assign de_c      = (h_cnt >= HA0) && (h_cnt < HA1) && (v_cnt >= VA0) && (v_cnt < VA1);
  assign x_c       = de_c ? 11'(h_cnt - HA0) : 11'd0;
  assign y_c       = de_c ? 11'(v_cnt - VA0) : 11'd0;

`ifdef VGA_PATTERN_SCROLL_EN
  localparam logic [10:0] HV = 11'(H_VALID);
  logic [10:0] offset;
  logic [11:0] x_sum;

  assign x_sum  = {1'b0, x_c} + {1'b0, offset};
  assign px_pat = (x_sum >= {1'b0, HV}) ? 11'(x_sum - {1'b0, HV}) : x_sum[10:0];

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      offset <= 11'd0;
    else if (frame_top)
      offset <= (offset == HV - 11'd1) ? 11'd0 : offset + 11'd1;
  end
`else
  assign px_pat = x_c;
`endif

  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++)
      if (px_pat >= 11'(i) * BAR_W) bar = 3'(i);
  end

  always_comb begin
    pat = '0;
    case (mode_q)
      2'd0: pat = {{R_W{BAR_LUT[bar][2]}}, {G_W{BAR_LUT[bar][1]}}, {B_W{BAR_LUT[bar][0]}}};
      2'd1: pat = (px_pat[5] ^ y_c[5]) ? '0 : '1;
      2'd2: pat = {px_pat[9 -: R_W], px_pat[9 -: G_W], px_pat[9 -: B_W]};
      default: pat = solid_rgb;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      h_cnt       <= 12'd0;
      v_cnt       <= 12'd0;
      mode_q      <= 2'd0;
      hsync       <= ~SP;
      vsync       <= ~SP;
      de          <= 1'b0;
      rgb         <= '0;
      pix_x       <= 11'd0;
      pix_y       <= 11'd0;
      frame_start <= 1'b0;
    end else begin
      h_cnt <= h_last ? 12'd0 : h_cnt + 12'd1;
      if (h_last) v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
      // Mode only changes on the frame boundary so a frame is never split.
      if (frame_top) mode_q <= mode;
      hsync       <= (h_cnt < HS_END) ? SP : ~SP;
      vsync       <= (v_cnt < VS_END) ? SP : ~SP;
      de          <= de_c;
      rgb         <= de_c ? pat : '0;
      pix_x       <= x_c;
      pix_y       <= y_c;
      frame_start <= frame_top;
    end
  end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed vector bench for vga_pattern_gen using a reduced 76x46 timing.
module tb_vga_pattern_gen;
  localparam int HT = 76;
  localparam int VT = 46;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic [15:0] rgb;
  logic        hsync, vsync, de, frame_start;
  logic [10:0] pix_x, pix_y;

  int total = 0;
  int bad = 0;
  int pos = -1;

  vga_pattern_gen #(
    .H_SYNC(4), .H_BACK(4), .H_VALID(64), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(2), .V_VALID(40), .V_FRONT(2)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .mode(mode), .solid_rgb(solid_rgb),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          f, v, h;
    logic        de;
    logic [15:0] rgb;
    logic        hs, vs;
    logic [10:0] px, py;
    int          next_mode;
    int          next_solid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int f, v, h, input logic e, input logic [15:0] c,
                     input logic hs, vs, input int px, py,
                     input int nm = -1, input int ns = -1);
    vec_t r;
    r.f = f; r.v = v; r.h = h; r.de = e; r.rgb = c; r.hs = hs; r.vs = vs;
    r.px = 11'(px); r.py = 11'(py); r.next_mode = nm; r.next_solid = ns;
    tbl.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic goto(input int f, v, h);
    int target;
    target = f * FT + v * HT + h;
    while (pos < target) step();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int hs_lo, vs_lo, de_hi, fs_n;
    logic [63:0] got, want;

    // Frame 0: colorbar timing and bars
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 3, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 4, 0, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 10, 0, 16'h0000, 1, 0, 0, 0);
    add(0, 2, 10, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 4, 7, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 4, 8, 1, 16'hFFFF, 1, 1, 0, 0);
    add(0, 4, 16, 1, 16'hFFE0, 1, 1, 8, 0);
    add(0, 5, 24, 1, 16'h07FF, 1, 1, 16, 1);
    add(0, 6, 32, 1, 16'h07E0, 1, 1, 24, 2);
    add(0, 7, 40, 1, 16'hF81F, 1, 1, 32, 3);
    add(0, 8, 48, 1, 16'hF800, 1, 1, 40, 4);
    add(0, 9, 56, 1, 16'h001F, 1, 1, 48, 5);
    add(0, 20, 64, 1, 16'h0000, 1, 1, 56, 16, 1);
    add(0, 30, 15, 1, 16'hFFFF, 1, 1, 7, 26);
    add(0, 43, 71, 1, 16'h0000, 1, 1, 63, 39);
    add(0, 43, 72, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 44, 8, 0, 16'h0000, 1, 1, 0, 0);
    // Frame 1: checkerboard
    add(1, 4, 8, 1, 16'hFFFF, 1, 1, 0, 0);
    add(1, 4, 39, 1, 16'hFFFF, 1, 1, 31, 0);
    add(1, 4, 40, 1, 16'h0000, 1, 1, 32, 0);
    add(1, 36, 8, 1, 16'h0000, 1, 1, 0, 32);
    add(1, 36, 40, 1, 16'hFFFF, 1, 1, 32, 32, 2);
    // Frame 2: gradient; switch to solid mid-frame
    add(2, 4, 8, 1, 16'h0000, 1, 1, 0, 0);
    add(2, 10, 48, 1, 16'h0841, 1, 1, 40, 6);
    add(2, 10, 71, 1, 16'h0861, 1, 1, 63, 6, 3, 'hF800);
    add(2, 11, 71, 1, 16'h0861, 1, 1, 63, 7);
    // Frame 3: solid, colour followed every cycle
    add(3, 4, 8, 1, 16'hF800, 1, 1, 0, 0, -1, 'h001F);
    add(3, 4, 9, 1, 16'h001F, 1, 1, 1, 0);
    add(3, 4, 72, 0, 16'h0000, 1, 1, 0, 0);

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_state", {59'd0, hsync, vsync, de, frame_start, |rgb}, {59'd0, 5'b11000});
    end
    rst = 1'b0;
    pos = -1;
    step();
    check("first_frame_start", {63'd0, frame_start}, 64'd1);

    foreach (tbl[i]) begin
      goto(tbl[i].f, tbl[i].v, tbl[i].h);
      got  = {20'd0, de, rgb, hsync, vsync, pix_x, pix_y, frame_start};
      want = {20'd0, tbl[i].de, tbl[i].rgb, tbl[i].hs, tbl[i].vs, tbl[i].px, tbl[i].py,
              1'(tbl[i].v == 0 && tbl[i].h == 0)};
      check($sformatf("vec%0d_f%0d_v%0d_h%0d", i, tbl[i].f, tbl[i].v, tbl[i].h), got, want);
      if (tbl[i].next_mode >= 0) mode = 2'(tbl[i].next_mode);
      if (tbl[i].next_solid >= 0) solid_rgb = 16'(tbl[i].next_solid);
    end

    // Free-run one full frame and count sync / de / frame_start cycles
    goto(4, 0, 0);
    hs_lo = 0; vs_lo = 0; de_hi = 0; fs_n = 0;
    for (int i = 0; i < FT; i++) begin
      hs_lo += int'(!hsync);
      vs_lo += int'(!vsync);
      de_hi += int'(de);
      fs_n  += int'(frame_start);
      step();
    end
    check("hsync_low_count", 64'(hs_lo), 64'(4 * VT));
    check("vsync_low_count", 64'(vs_lo), 64'(2 * HT));
    check("de_high_count", 64'(de_hi), 64'(64 * 40));
    check("frame_start_count", 64'(fs_n), 64'd1);

    // Single-cycle reset in the middle of a frame
    goto(5, 20, 30);
    rst = 1'b1;
    step();
    check("midreset_state", {59'd0, hsync, vsync, de, frame_start, |rgb}, {59'd0, 5'b11000});
    rst = 1'b0;
    pos = -1;
    step();
    check("midreset_frame_start", {61'd0, frame_start, hsync, vsync}, 64'b100);
    step();
    check("midreset_pulse_width", {63'd0, frame_start}, 64'd0);
    goto(0, 4, 8);
    check("midreset_first_pixel", {35'd0, de, rgb, pix_x, pix_y},
          {35'd0, 1'b1, 16'h001F, 11'd0, 11'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_SYNC, 96, hsync width in pixel clocks
- H_BACK, 48, horizontal back porch
- H_VALID, 640, active pixels per line (8..1024, multiple of 8)
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch
- V_VALID, 480, active lines
- V_FRONT, 10, vertical front porch
- SYNC_POL, 0, sync active level (0 = active-low)
- R_W, 5, red width (1..8)
- G_W, 6, green width (1..8)
- B_W, 5, blue width (1..8)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- sys_clk, in, 1, pixel clock; sole clock
- sys_rst, in, 1, synchronous active-high reset
- mode, in, 2, 0 colorbar, 1 checkerboard, 2 gradient, 3 solid
- solid_rgb, in, R_W+G_W+B_W, colour used in solid mode
- rgb, out, R_W+G_W+B_W, {R,G,B} pixel
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- de, out, 1, active-video flag
- pix_x, out, 11, active column (0 when de=0)
- pix_y, out, 11, active row (0 when de=0)
- frame_start, out, 1, one-cycle pulse

Function
REQ-003 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H_* parameters) and wrap; v_cnt SHALL count 0..V_TOTAL-1, increment only when h_cnt wraps, and wrap when both counters are at their maximum.
REQ-004 hsync SHALL be active while h_cnt < H_SYNC; vsync SHALL be active while v_cnt < V_SYNC; active level = SYNC_POL.
REQ-005 de SHALL be 1 when h_cnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID) and v_cnt is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID).
REQ-006 pix_x/pix_y SHALL be the counter offsets from the start of the active window.
REQ-007 All outputs SHALL be registered from the same counter state, with 1-cycle latency and mutual alignment.
REQ-008 frame_start SHALL pulse for the cycle in which outputs reflect h_cnt=0, v_cnt=0.
REQ-009 mode SHALL be sampled into mode_q only at h_cnt=0, v_cnt=0; mid-frame changes SHALL take effect from the next frame.
REQ-010 Colorbar SHALL show 8 bars, each H_VALID/8 wide, in this order: white, yellow, cyan, green, magenta, red, blue, black. Full-scale channels SHALL be all-ones; off channels SHALL be zero.
REQ-011 Checkerboard SHALL output white when pix_x[5]^pix_y[5]=0, black otherwise.
REQ-012 Gradient SHALL set each channel to pix_x[9 -: width] (grey ramp).
REQ-013 Solid SHALL output solid_rgb, sampled every cycle.
REQ-014 rgb SHALL be 0 whenever de=0.

Reset
REQ-015 While sys_rst=1 at a sys_clk edge, the block SHALL set h_cnt=0, v_cnt=0, mode_q=0, scroll offset=0, de=0, rgb=0, pix_x=0, pix_y=0, frame_start=0, and hsync/vsync to the inactive level (~SYNC_POL).
REQ-016 Reset mid-frame SHALL abort the frame. The first post-reset cycle SHALL start a new frame with a frame_start pulse.

Configuration
REQ-017 With VGA_PATTERN_SCROLL_EN defined, an offset register SHALL increment by 1 modulo H_VALID at each frame_start. Pattern generation SHALL use (pix_x + offset) mod H_VALID in place of pix_x; the pix_x output SHALL be unchanged.
REQ-018 Without VGA_PATTERN_SCROLL_EN, no offset logic SHALL exist and patterns SHALL be static.

Verification
REQ-019 Default parameters, reset held for 3 cycles -> hsync=1, vsync=1, de=0, rgb=0 during reset; first cycle after release has frame_start=1.
REQ-020 Free run -> hsync low for 96 of every 800 cycles; vsync low for 1600 of every 420000 cycles; 640 de-high cycles per active line.
REQ-021 mode=0, RGB565 -> pix_x=0 gives rgb=16'hFFFF; pix_x=80 gives 16'hFFE0; pix_x=560 gives 16'h0000.
REQ-022 mode switched 0->3 at line 100, solid_rgb=16'hF800 -> current frame stays colorbar; next frame is all 16'hF800 on de.
REQ-023 Reset asserted at v_cnt=200 for 1 cycle -> counters restart at 0; frame_start pulses immediately after release.
REQ-024 With VGA_PATTERN_SCROLL_EN, mode=0 -> in frame 80 (offset 80), pix_x=0 shows 16'hFFE0.
